// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle CPU control FSM.
// Holds the state encoding, instruction classes, ALU compare opcode,
// branch condition codes, PSR flag bit positions and PC select codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_LOAD   = 4'd4,
        S_STORE  = 4'd5,
        S_BRANCH = 4'd6,
        S_RETIRE = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    localparam logic [3:0] CLS_NOP   = 4'h0;
    localparam logic [3:0] CLS_R     = 4'h1;
    localparam logic [3:0] CLS_I     = 4'h2;
    localparam logic [3:0] CLS_LOAD  = 4'h4;
    localparam logic [3:0] CLS_STORE = 4'h5;
    localparam logic [3:0] CLS_BCOND = 4'h8;
    localparam logic [3:0] CLS_JCOND = 4'h9;

    // ALU compare only updates flags, never the register file.
    localparam int OP_CMP = 7;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;

    // flags_in = {N, Z, F, L, C}
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_C = 0;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_DISP = 2'd1;
    localparam logic [1:0] PC_REG  = 2'd2;

    // Branch classes are only decodable when branch support is built in.
    function automatic logic class_is_legal(input logic [3:0] cls, input logic branch_en);
        case (cls)
            CLS_NOP, CLS_R, CLS_I, CLS_LOAD, CLS_STORE: return 1'b1;
            CLS_BCOND, CLS_JCOND:                       return branch_en;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: IR field inputs, memory handshake and datapath strobes
// between the control FSM (master) and the datapath/RAM (slave).
interface cpu_ctrl_fsm_if #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 5,
    parameter int OPCODE_W  = 8,
    parameter int IMM_W     = 8
);
    logic [3:0]           instr_class;
    logic [OPCODE_W-1:0]  opcode_in;
    logic [REG_IDX_W-1:0] rdst_in;
    logic [REG_IDX_W-1:0] rsrc_in;
    logic [IMM_W-1:0]     imm_in;
    logic [3:0]           cond_in;
    logic [4:0]           flags_in;
    logic                 mem_ready;

    logic                 ir_en;
    logic                 pc_en;
    logic                 flag_en;
    logic                 imm_sel;
    logic                 bus_en;
    logic                 mem_req;
    logic                 mem_we;
    logic                 wb_sel;
    logic                 addr_sel;
    logic [1:0]           pc_sel;
    logic [NUM_REGS-1:0]  rf_we;
    logic [REG_IDX_W-1:0] rsrc_out;
    logic [REG_IDX_W-1:0] rdst_out;
    logic [OPCODE_W-1:0]  opcode_out;
    logic [IMM_W-1:0]     imm_out;
    logic                 illegal;
    logic                 fault;
    logic                 instr_done;
    logic [3:0]           state_out;

    modport master (
        input  instr_class, opcode_in, rdst_in, rsrc_in, imm_in, cond_in, flags_in, mem_ready,
        output ir_en, pc_en, flag_en, imm_sel, bus_en, mem_req, mem_we, wb_sel, addr_sel,
               pc_sel, rf_we, rsrc_out, rdst_out, opcode_out, imm_out, illegal, fault,
               instr_done, state_out
    );

    modport slave (
        output instr_class, opcode_in, rdst_in, rsrc_in, imm_in, cond_in, flags_in, mem_ready,
        input  ir_en, pc_en, flag_en, imm_sel, bus_en, mem_req, mem_we, wb_sel, addr_sel,
               pc_sel, rf_we, rsrc_out, rdst_out, opcode_out, imm_out, illegal, fault,
               instr_done, state_out
    );
endinterface

// File: rtl/cpu_cond_eval.sv
// cpu_cond_eval: evaluates a branch condition code against the PSR flags.
// Only built when CPU_CTRL_BRANCH_EN is defined.
`ifdef CPU_CTRL_BRANCH_EN
module cpu_cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);
    logic n, z, f, l, c;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign f = flags[FLAG_F];
    assign l = flags[FLAG_L];
    assign c = flags[FLAG_C];

    // Condition decode; code 15 is reserved and never taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_HI: taken = l;
            COND_LS: taken = !l;
            COND_GT: taken = n;
            COND_LE: taken = !n;
            COND_FS: taken = f;
            COND_FC: taken = !f;
            COND_LO: taken = !z && !l;
            COND_HS: taken = z || l;
            COND_LT: taken = !z && !n;
            COND_GE: taken = z || n;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule
`endif

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle fetch/decode/execute sequencer for the 16-bit datapath,
// with a memory-ready watchdog that halts on timeout.
// Define CPU_CTRL_BRANCH_EN to decode BCOND/JCOND; otherwise they retire as illegal.
//
// state    | meaning
// S_RESET  | first cycle after reset, every strobe low
// S_FETCH  | read instruction at PC, load IR when memory is ready
// S_DECODE | IR stable, select execution path, flag illegal classes
// S_EXEC   | ALU op on register/immediate operands, write back, PC+1
// S_LOAD   | read RAM at [rsrc], write rdst when ready, PC+1
// S_STORE  | write rdst to RAM at [rsrc], PC+1 when ready
// S_BRANCH | conditional PC update (displacement or register target)
// S_RETIRE | NOP / illegal instruction, PC+1
// S_HALT   | watchdog expired, fault held until reset
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 5,
    parameter int OPCODE_W  = 8,
    parameter int IMM_W     = 8,
    parameter int WAIT_MAX  = 15
) (
    input  logic           clk,
    input  logic           reset,
    cpu_ctrl_fsm_if.master bus
);
    localparam int               CNT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
`ifdef CPU_CTRL_BRANCH_EN
    localparam logic BRANCH_EN = 1'b1;
`else
    localparam logic BRANCH_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;

    logic [3:0]           instr_class;
    logic [OPCODE_W-1:0]  opcode;
    logic [REG_IDX_W-1:0] rdst;
    logic [REG_IDX_W-1:0] rsrc;
    logic [IMM_W-1:0]     imm;
    logic                 mem_ready;
    logic [NUM_REGS-1:0]  wr_onehot;
    logic                 is_cmp;
    logic                 class_legal;

    logic                 ir_en, pc_en, flag_en, imm_sel, bus_en;
    logic                 mem_req, mem_we, wb_sel, addr_sel, illegal;
    logic [1:0]           pc_sel;
    logic [NUM_REGS-1:0]  rf_we;
    logic [REG_IDX_W-1:0] rsrc_out, rdst_out;
    logic [OPCODE_W-1:0]  opcode_out;
    logic [IMM_W-1:0]     imm_out;

    assign instr_class = bus.instr_class;
    assign opcode      = bus.opcode_in;
    assign rdst        = bus.rdst_in;
    assign rsrc        = bus.rsrc_in;
    assign imm         = bus.imm_in;
    assign mem_ready   = bus.mem_ready;
    assign is_cmp      = (opcode == OPCODE_W'(OP_CMP));
    assign class_legal = class_is_legal(instr_class, BRANCH_EN);

`ifdef CPU_CTRL_BRANCH_EN
    logic taken;

    cpu_cond_eval u_cond_eval (
        .cond  (bus.cond_in),
        .flags (bus.flags_in),
        .taken (taken)
    );
`endif

    // Register write enable; indices beyond the register bank drop the write.
    always_comb begin
        wr_onehot = '0;
        if (int'(rdst) < NUM_REGS) begin
            wr_onehot = NUM_REGS'(1) << rdst;
        end
    end

    // Next state, watchdog count and sticky fault.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        fault_d    = fault_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH, S_LOAD, S_STORE: begin
                // a ready in the final allowed cycle still completes the access
                if (mem_ready) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE : S_FETCH;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_RETIRE;
                if (class_legal) begin
                    case (instr_class)
                        CLS_R, CLS_I: state_d = S_EXEC;
                        CLS_LOAD:     state_d = S_LOAD;
                        CLS_STORE:    state_d = S_STORE;
`ifdef CPU_CTRL_BRANCH_EN
                        CLS_BCOND, CLS_JCOND: state_d = S_BRANCH;
`endif
                        default:      state_d = S_RETIRE;
                    endcase
                end
            end
            S_EXEC, S_RETIRE: state_d = S_FETCH;
`ifdef CPU_CTRL_BRANCH_EN
            S_BRANCH: state_d = S_FETCH;
`endif
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    // State register with synchronous reset; a pending access is simply abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Datapath strobes decoded from state; memory completions gated by mem_ready.
    always_comb begin
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        flag_en    = 1'b0;
        imm_sel    = 1'b0;
        bus_en     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        wb_sel     = 1'b0;
        addr_sel   = 1'b0;
        illegal    = 1'b0;
        pc_sel     = PC_INC;
        rf_we      = '0;
        rsrc_out   = '0;
        rdst_out   = '0;
        opcode_out = '0;
        imm_out    = '0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_en   = mem_ready;
            end
            S_DECODE: illegal = !class_legal;
            S_EXEC: begin
                bus_en     = 1'b1;
                flag_en    = 1'b1;
                imm_sel    = (instr_class == CLS_I);
                opcode_out = opcode;
                rsrc_out   = rsrc;
                rdst_out   = rdst;
                imm_out    = imm;
                rf_we      = is_cmp ? '0 : wr_onehot;
                pc_en      = 1'b1;
            end
            S_LOAD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                rsrc_out = rsrc;
                rdst_out = rdst;
                wb_sel   = mem_ready;
                rf_we    = mem_ready ? wr_onehot : '0;
                pc_en    = mem_ready;
            end
            S_STORE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                rsrc_out = rsrc;
                rdst_out = rdst;
                pc_en    = mem_ready;
            end
`ifdef CPU_CTRL_BRANCH_EN
            S_BRANCH: begin
                pc_en    = 1'b1;
                rsrc_out = rsrc;
                imm_out  = imm;
                if (taken) begin
                    pc_sel = (instr_class == CLS_BCOND) ? PC_DISP : PC_REG;
                end
            end
`endif
            S_RETIRE: pc_en = 1'b1;
            default: ;
        endcase
    end

    assign bus.ir_en      = ir_en;
    assign bus.pc_en      = pc_en;
    assign bus.flag_en    = flag_en;
    assign bus.imm_sel    = imm_sel;
    assign bus.bus_en     = bus_en;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.wb_sel     = wb_sel;
    assign bus.addr_sel   = addr_sel;
    assign bus.pc_sel     = pc_sel;
    assign bus.rf_we      = rf_we;
    assign bus.rsrc_out   = rsrc_out;
    assign bus.rdst_out   = rdst_out;
    assign bus.opcode_out = opcode_out;
    assign bus.imm_out    = imm_out;
    assign bus.illegal    = illegal;
    assign bus.fault      = fault_q;
    assign bus.instr_done = pc_en;
    assign bus.state_out  = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: instruction-level reference model driving randomized
// instructions and memory wait patterns, checked cycle by cycle.
module tb_cpu_ctrl_fsm;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 5;
    localparam int OPCODE_W  = 8;
    localparam int IMM_W     = 8;
    localparam int WAIT_MAX  = 15;
    localparam logic [7:0] OP_CMP_TB = 8'h07;
`ifdef CPU_CTRL_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_if #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W),
                      .OPCODE_W(OPCODE_W), .IMM_W(IMM_W)) bus ();

    cpu_ctrl_fsm #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W), .OPCODE_W(OPCODE_W),
                   .IMM_W(IMM_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] obs_s;
    assign obs_s = {18'b0, bus.mem_req, bus.mem_we, bus.ir_en, bus.pc_en, bus.instr_done,
                    bus.flag_en, bus.bus_en, bus.wb_sel, bus.addr_sel, bus.imm_sel,
                    bus.illegal, bus.fault, bus.pc_sel};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // instr_done is expected wherever pc_en is expected
    function automatic logic [31:0] mk(input bit mreq, input bit mwe, input bit ir, input bit pc,
                                       input bit flag, input bit bse, input bit wb, input bit addr,
                                       input bit imm, input bit ill, input bit flt,
                                       input logic [1:0] psel);
        return {18'b0, mreq, mwe, ir, pc, pc, flag, bse, wb, addr, imm, ill, flt, psel};
    endfunction

    function automatic bit cond_taken(input logic [3:0] c, input logic [4:0] f);
        bit n, z, fl, l, cy;
        n = f[4]; z = f[3]; fl = f[2]; l = f[1]; cy = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return fl;
            4'd9:  return !fl;
            4'd10: return !z && !l;
            4'd11: return z || l;
            4'd12: return !z && !n;
            4'd13: return z || n;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cyc(input logic rdy);
        @(posedge clk);
        #1;
        bus.mem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic chk_cyc(input string tag, input logic [31:0] e, input logic [15:0] erf);
        chk({tag, "/strobes"}, obs_s, e);
        chk({tag, "/rf_we"}, 32'(bus.rf_we), 32'(erf));
    endtask

    task automatic halt_phase();
        for (int k = 0; k < 3; k++) begin
            cyc((k == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
            chk_cyc("halt", mk(0,0,0,0,0,0,0,0,0,0,1,2'd0), 16'h0);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_cyc(tag, mk(0,0,0,0,0,0,0,0,0,0,0,2'd0), 16'h0);
        chk({tag, "/fields"}, {bus.rsrc_out, bus.rdst_out, bus.opcode_out, bus.imm_out}, 32'h0);
    endtask

    // One instruction: wf/wm are low-ready cycles before the fetch/data access
    // completes; abort_m >= 0 returns early inside the data access.
    task automatic run_instr(input logic [3:0] cls, input logic [7:0] op, input logic [4:0] rd,
                             input logic [4:0] rs, input logic [7:0] imm, input logic [3:0] cond,
                             input logic [4:0] flags, input int wf, input int wm,
                             input int abort_m, output bit halted);
        logic [15:0] oh;
        logic [1:0]  psel;
        bit          legal, rdy, is_br;
        halted = 1'b0;
        oh     = (int'(rd) < NUM_REGS) ? (16'h1 << rd) : 16'h0;
        is_br  = (cls == 4'h8) || (cls == 4'h9);
        legal  = (cls == 4'h0) || (cls == 4'h1) || (cls == 4'h2) || (cls == 4'h4) ||
                 (cls == 4'h5) || (BR_EN && is_br);
        bus.instr_class = cls; bus.opcode_in = op; bus.rdst_in = rd; bus.rsrc_in = rs;
        bus.imm_in = imm; bus.cond_in = cond; bus.flags_in = flags;

        for (int k = 0; k <= wf; k++) begin
            rdy = (k == wf);
            cyc(rdy);
            chk_cyc("fetch", mk(1,0,rdy,0,0,0,0,0,0,0,0,2'd0), 16'h0);
            if (rdy) break;
            if (k == WAIT_MAX - 1) begin
                halt_phase();
                halted = 1'b1;
                return;
            end
        end

        cyc(1'($urandom_range(0, 1)));
        chk_cyc("decode", mk(0,0,0,0,0,0,0,0,0,!legal,0,2'd0), 16'h0);

        if (legal && (cls == 4'h1 || cls == 4'h2)) begin
            cyc(1'($urandom_range(0, 1)));
            chk_cyc("exec", mk(0,0,0,1,1,1,0,0,(cls == 4'h2),0,0,2'd0),
                    (op == OP_CMP_TB) ? 16'h0 : oh);
            chk("exec_op", 32'(bus.opcode_out), 32'(op));
            chk("exec_regs", {bus.rsrc_out, bus.rdst_out}, {rs, rd});
            chk("exec_imm", 32'(bus.imm_out), 32'(imm));
        end else if (cls == 4'h4 || cls == 4'h5) begin
            for (int k = 0; k <= wm; k++) begin
                if (k == abort_m) return;
                rdy = (k == wm);
                cyc(rdy);
                if (cls == 4'h4)
                    chk_cyc("load", mk(1,0,0,rdy,0,0,rdy,1,0,0,0,2'd0), rdy ? oh : 16'h0);
                else
                    chk_cyc("store", mk(1,1,0,rdy,0,0,0,1,0,0,0,2'd0), 16'h0);
                chk("mem_regs", {bus.rsrc_out, bus.rdst_out}, {rs, rd});
                if (rdy) break;
                if (k == WAIT_MAX - 1) begin
                    halt_phase();
                    halted = 1'b1;
                    return;
                end
            end
        end else if (legal && is_br) begin
            psel = cond_taken(cond, flags) ? ((cls == 4'h8) ? 2'd1 : 2'd2) : 2'd0;
            cyc(1'($urandom_range(0, 1)));
            chk_cyc("branch", mk(0,0,0,1,0,0,0,0,0,0,0,psel), 16'h0);
        end else begin
            cyc(1'($urandom_range(0, 1)));
            chk_cyc("retire", mk(0,0,0,1,0,0,0,0,0,0,0,2'd0), 16'h0);
        end
    endtask

    logic [3:0] cls_tab [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hF, 4'h7};

    initial begin
        bit         h;
        int         wf, wm;
        logic [7:0] op;
        bus.instr_class = '0; bus.opcode_in = '0; bus.rdst_in = '0; bus.rsrc_in = '0;
        bus.imm_in = '0; bus.cond_in = '0; bus.flags_in = '0; bus.mem_ready = 1'b0;

        do_reset("rst0");
        run_instr(4'h1, 8'h01, 5'd3, 5'd5, 8'h00, 4'd0, 5'b0, 0, 0, -1, h);          // ADD r3,r5
        run_instr(4'h4, 8'h00, 5'd2, 5'd7, 8'h00, 4'd0, 5'b0, 0, 4, -1, h);          // LOAD r2<-[r7]
        run_instr(4'hF, 8'h01, 5'd6, 5'd1, 8'h00, 4'd0, 5'b0, 0, 0, -1, h);          // illegal
        run_instr(4'h1, OP_CMP_TB, 5'd4, 5'd1, 8'h00, 4'd0, 5'b0, 1, 0, -1, h);      // CMP
        run_instr(4'h2, 8'h03, 5'd9, 5'd2, 8'hA5, 4'd0, 5'b0, 0, 0, -1, h);          // I-type
        run_instr(4'h1, 8'h01, 5'd20, 5'd1, 8'h00, 4'd0, 5'b0, 0, 0, -1, h);         // rdst out of range
        run_instr(4'h4, 8'h00, 5'd17, 5'd1, 8'h00, 4'd0, 5'b0, 0, 1, -1, h);
        run_instr(4'h8, 8'h00, 5'd0, 5'd0, 8'h10, 4'd0, 5'b01000, 0, 0, -1, h);      // BCOND EQ, Z=1
        run_instr(4'h8, 8'h00, 5'd0, 5'd0, 8'h10, 4'd0, 5'b00000, 0, 0, -1, h);      // BCOND EQ, Z=0
        run_instr(4'h9, 8'h00, 5'd0, 5'd3, 8'h00, 4'd14, 5'b00000, 0, 0, -1, h);     // JCOND UC
        run_instr(4'h0, 8'h00, 5'd0, 5'd0, 8'h00, 4'd0, 5'b0, WAIT_MAX - 1, 0, -1, h);
        run_instr(4'h5, 8'h00, 5'd1, 5'd2, 8'h00, 4'd0, 5'b0, 0, WAIT_MAX - 1, -1, h);
        run_instr(4'h5, 8'h00, 5'd1, 5'd2, 8'h00, 4'd0, 5'b0, 0, 100, 3, h);         // reset mid-store
        do_reset("rst_store");
        run_instr(4'h5, 8'h00, 5'd1, 5'd2, 8'h00, 4'd0, 5'b0, 0, 1000, -1, h);       // watchdog
        do_reset("rst_halt");
        run_instr(4'h0, 8'h00, 5'd0, 5'd0, 8'h00, 4'd0, 5'b0, WAIT_MAX, 0, -1, h);   // fetch watchdog
        do_reset("rst_halt_f");

        repeat (200) begin
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WAIT_MAX + 1) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, WAIT_MAX + 1) : $urandom_range(0, 3);
            op = ($urandom_range(0, 3) == 0) ? OP_CMP_TB : 8'($urandom);
            run_instr(cls_tab[$urandom_range(0, 9)], op, 5'($urandom), 5'($urandom),
                      8'($urandom), 4'($urandom), 5'($urandom), wf, wm, -1, h);
            if (h) do_reset("rst_rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
